// File: rtl/ca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ca_pkg
// Purpose  : Shared constants and types for the CA generator, the row
//            scan-out reader and the VESA timing block.
// Revision : 1.0 - initial release
// ============================================================================
package ca_pkg;

  localparam int CA_WORDS      = 80;  // words per row
  localparam int CA_WIDTH      = 16;  // bits per memory word
  localparam int CA_ADDR_W     = 8;   // generation RAM address width
  localparam int CA_BANK1_BASE = 80;  // bank 1 base address (bank 0 is at 0)

  // Scan-out sequencing: fetch two words, stream, flag completion.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFETCH = 2'd1,
    ST_STREAM   = 2'd2,
    ST_DONE     = 2'd3
  } scan_state_t;

endpackage : ca_pkg
`default_nettype wire

// File: rtl/ca_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : ca_word_serializer
// Purpose  : One-word shift register with a bit counter. Presents the MSB as
//            the current pixel and flags the shift that consumes the last bit.
// Revision : 1.0 - initial release
// ============================================================================
module ca_word_serializer
  import ca_pkg::*;
#(
  parameter int WIDTH = CA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,      // drop the current word and bit position
  input  logic             load,       // take load_word; wins over shift_en
  input  logic [WIDTH-1:0] load_word,
  input  logic             shift_en,   // consume one pixel
  output logic             msb,
  output logic             word_done   // shift_en on the last bit of the word
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    bit_cnt;

  assign msb       = shift_q[WIDTH-1];
  assign word_done = shift_en && (bit_cnt == CW'(WIDTH - 1));

  // Shift register and bit position; a load restarts the bit count.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shift_q <= load_word;
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

endmodule : ca_word_serializer
`default_nettype wire

// File: rtl/ca_row_scanout.sv
`default_nettype none
// ============================================================================
// Module   : ca_row_scanout
// Purpose  : Fetches one row of the CA generation memory from the selected
//            bank and serialises it MSB-first, one pixel per active cycle.
//            Keeps at most two words in flight (shift register + next word).
// Revision : 1.0 - initial release
// ============================================================================
module ca_row_scanout
  import ca_pkg::*;
#(
  parameter int WORDS      = CA_WORDS,
  parameter int WIDTH      = CA_WIDTH,
  parameter int ADDR_W     = CA_ADDR_W,
  parameter int BANK1_BASE = CA_BANK1_BASE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_start,
  input  logic              bank,
  input  logic              active,
  output logic              read,
  output logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  rdata,
  output logic              pixel,
  output logic              ready,
  output logic              underrun,
  output logic              line_done
);

  localparam int CNT_W = $clog2(WORDS + 1);

  scan_state_t      state_q, state_d;
  logic             pf_second;   // second prefetch read has been issued
  logic             rd_q;        // rdata this cycle answers last cycle's read
  logic [CNT_W-1:0] rd_cnt;      // reads issued for the current row
  logic [CNT_W-1:0] word_cnt;    // words fully consumed
  logic [WIDTH-1:0] next_word;

  logic             ser_msb;
  logic             word_done;
  logic             shift_en;
  logic             ser_load;
  logic [WIDTH-1:0] ser_word;

  // A line_start cycle never consumes a pixel, even mid-row.
  assign shift_en = (state_q == ST_STREAM) && active && !line_start;
  // First fetched word goes straight to the shifter; later ones via next_word.
  assign ser_load = ((state_q == ST_PREFETCH) && pf_second) || word_done;
  assign ser_word = (state_q == ST_PREFETCH) ? rdata : next_word;

  ca_word_serializer #(
    .WIDTH(WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (line_start),
    .load      (ser_load),
    .load_word (ser_word),
    .shift_en  (shift_en),
    .msb       (ser_msb),
    .word_done (word_done)
  );

  // Next-state and status outputs decoded from the current state.
  always_comb begin
    state_d   = state_q;
    pixel     = 1'b0;
    ready     = 1'b0;
    line_done = 1'b0;
    case (state_q)
      ST_IDLE:     state_d = ST_IDLE;
      ST_PREFETCH: if (pf_second) state_d = ST_STREAM;
      ST_STREAM: begin
        ready = 1'b1;
        pixel = ser_msb && !line_start;
        if (word_done && (word_cnt == CNT_W'(WORDS - 1))) state_d = ST_DONE;
      end
      ST_DONE: begin
        line_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (line_start) state_d = ST_PREFETCH;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Read address generation, prefetch buffer, counters and underrun flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      read      <= 1'b0;
      raddr     <= '0;
      rd_q      <= 1'b0;
      pf_second <= 1'b0;
      rd_cnt    <= '0;
      word_cnt  <= '0;
      next_word <= '0;
      underrun  <= 1'b0;
    end else begin
      read <= 1'b0;
      rd_q <= read;
      if (line_start) begin
        read      <= 1'b1;
        raddr     <= bank ? ADDR_W'(BANK1_BASE) : '0;
        rd_q      <= 1'b0;
        pf_second <= 1'b0;
        rd_cnt    <= CNT_W'(1);
        word_cnt  <= '0;
        underrun  <= 1'b0;
      end else begin
        if (active && (state_q != ST_STREAM)) underrun <= 1'b1;
        case (state_q)
          ST_PREFETCH: begin
            if (!pf_second) begin
              read      <= 1'b1;
              raddr     <= raddr + ADDR_W'(1);
              rd_cnt    <= rd_cnt + CNT_W'(1);
              pf_second <= 1'b1;
            end
          end
          ST_STREAM: begin
            if (rd_q) next_word <= rdata;
            // Refill only after the buffered word moves into the shifter,
            // which keeps the fetch at most two words ahead.
            if (word_done) begin
              word_cnt <= word_cnt + CNT_W'(1);
              if (rd_cnt < CNT_W'(WORDS)) begin
                read   <= 1'b1;
                raddr  <= raddr + ADDR_W'(1);
                rd_cnt <= rd_cnt + CNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule : ca_row_scanout
`default_nettype wire

// File: tb/tb_ca_row_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_row_scanout
// Purpose  : Self-checking bench for ca_row_scanout. Expected pixels come from
//            the row contents read MSB-first as one long bit string.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_row_scanout;

  localparam int NPIX = 80 * 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic        bank;
  logic        active;
  logic        read;
  logic [7:0]  raddr;
  logic [15:0] rdata;
  logic        pixel;
  logic        ready;
  logic        underrun;
  logic        line_done;

  logic [15:0] mem [0:159];
  int          rq[$];
  int          ld_count = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ca_row_scanout dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .bank       (bank),
    .active     (active),
    .read       (read),
    .raddr      (raddr),
    .rdata      (rdata),
    .pixel      (pixel),
    .ready      (ready),
    .underrun   (underrun),
    .line_done  (line_done)
  );

  // Synchronous-read memory: data appears the cycle after the address.
  always @(posedge clk) rdata <= mem[raddr];

  // Record every read address and every line_done pulse.
  always @(negedge clk) begin
    if (read === 1'b1) rq.push_back(int'(raddr));
    if (line_done === 1'b1) ld_count++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // amode: 0 contiguous active, 1 alternating, 2 random gaps.
  // abort_at >= 0 leaves the row mid-stream after that many pixels.
  task automatic run_row(input logic b, input int amode, input int abort_at,
                         input bit early, input bit ls_act);
    logic [15:0] w [80];
    int base, p, budget, ld0, bad;
    logic expb;
    base = b ? 80 : 0;
    for (int k = 0; k < 80; k++) w[k] = mem[base + k];
    ld0 = ld_count;
    // cycle T
    tick(); line_start = 1'b1; bank = b; active = ls_act;
    @(negedge clk);
    if (ls_act) chk("ls_active_pixel", pixel, 0);
    // T+1
    tick(); line_start = 1'b0; bank = 1'($urandom); active = early;
    rq.delete();
    @(negedge clk);
    chk("t1_read", read, 1);
    chk("t1_raddr", raddr, base);
    chk("t1_ready", ready, 0);
    chk("t1_underrun", underrun, 0);
    chk("t1_pixel", pixel, 0);
    chk("t1_line_done", line_done, 0);
    // T+2
    tick(); active = 1'b0;
    @(negedge clk);
    chk("t2_read", read, 1);
    chk("t2_raddr", raddr, base + 1);
    chk("t2_underrun", underrun, early);
    // streaming
    p = 0; budget = 0;
    while (p < NPIX && p != abort_at && budget < 5000) begin
      tick();
      case (amode)
        0:       active = 1'b1;
        1:       active = (budget % 2 == 0);
        default: active = ($urandom_range(0, 3) != 0);
      endcase
      budget++;
      @(negedge clk);
      if (budget == 1) begin
        chk("t3_ready", ready, 1);
        chk("t3_read", read, 0);
      end
      if (active) begin
        expb = w[p / 16][15 - (p % 16)];
        chk($sformatf("pixel[%0d]", p), pixel, expb);
        p++;
      end
    end
    tick(); active = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_reached", p, abort_at);
      chk("abort_no_line_done", ld_count, ld0);
    end else begin
      chk("row_complete", p, NPIX);
      @(negedge clk);
      chk("done_line_done", line_done, 1);
      chk("done_ready", ready, 0);
      chk("done_pixel", pixel, 0);
      tick();
      @(negedge clk);
      chk("idle_line_done", line_done, 0);
      chk("line_done_count", ld_count, ld0 + 1);
      chk("read_count", rq.size(), 80);
      bad = 0;
      for (int i = 0; i < rq.size(); i++) if (rq[i] != base + i) bad++;
      chk("read_sequence", bad, 0);
      chk("row_underrun", underrun, early);
    end
  endtask

  initial begin
    rst_n = 1'b0; line_start = 1'b0; bank = 1'b0; active = 1'b0;
    for (int i = 0; i < 160; i++) mem[i] = 16'($urandom);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_read", read, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_ready", ready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_line_done", line_done, 0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();

    // T1: walking-one pattern in bank 0
    for (int k = 0; k < 80; k++) mem[k] = 16'h8000 >> (k % 16);
    run_row(1'b0, 0, -1, 1'b0, 1'b0);
    // active after the row has ended is an underrun
    tick(); active = 1'b1;
    @(negedge clk);
    chk("post_row_pixel", pixel, 0);
    tick(); active = 1'b0;
    @(negedge clk);
    chk("post_row_underrun", underrun, 1);

    // T2: bank 1 with only its first word set
    for (int k = 80; k < 160; k++) mem[k] = 16'h0000;
    mem[80] = 16'hFFFF;
    run_row(1'b1, 0, -1, 1'b0, 1'b0);

    // T3: alternating active with a constant pattern
    for (int k = 0; k < 80; k++) mem[k] = 16'hA5A5;
    run_row(1'b0, 1, -1, 1'b0, 1'b0);

    // random contents, random active gaps
    for (int i = 0; i < 160; i++) mem[i] = 16'($urandom);
    run_row(1'b1, 2, -1, 1'b0, 1'b0);

    // T4: active during prefetch; the early pixel must not be consumed
    run_row(1'b0, 0, -1, 1'b1, 1'b0);

    // T5: abort at pixel 500, restart on the other bank with active high
    run_row(1'b0, 2, 500, 1'b0, 1'b0);
    run_row(1'b1, 0, -1, 1'b0, 1'b1);

    // T6: reset mid-stream
    run_row(1'b0, 0, 300, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    rq.delete();
    @(negedge clk);
    chk("rst6_read", read, 0);
    chk("rst6_raddr", raddr, 0);
    chk("rst6_pixel", pixel, 0);
    chk("rst6_ready", ready, 0);
    chk("rst6_underrun", underrun, 0);
    chk("rst6_line_done", line_done, 0);
    repeat (20) tick();
    chk("rst6_no_reads", rq.size(), 0);
    run_row(1'b1, 2, -1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ca_row_scanout
`default_nettype wire
